// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scheduler: slot record, FSM states, edge modes.
package sprite_pkg;

  localparam int unsigned EDGE_CLAMP = 0;
  localparam int unsigned EDGE_WRAP  = 1;

  // Slot fields are stored at fixed widths; the top checks its parameters fit.
  localparam int unsigned SLOT_COORD_W = 16;
  localparam int unsigned SLOT_VEL_W   = 8;
  localparam int unsigned SLOT_FRAME_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StEmit
  } sched_state_t;

  typedef struct packed {
    logic                    active;
    logic [SLOT_COORD_W-1:0] x;
    logic [SLOT_COORD_W-1:0] y;
    logic [SLOT_VEL_W-1:0]   dx;
    logic [SLOT_VEL_W-1:0]   dy;
    logic [SLOT_FRAME_W-1:0] frame;
  } sprite_slot_t;

endpackage

// File: rtl/edge_step.sv
// Combinational coordinate step: coord + signed vel, then clamp or wrap into [0, MAX-1].
module edge_step
  import sprite_pkg::*;
#(
  parameter int unsigned MAX     = 100,
  parameter int unsigned MODE    = EDGE_CLAMP,
  parameter int unsigned COORD_W = 16,
  parameter int unsigned VEL_W   = 8
) (
  input  logic [COORD_W-1:0] coord_i,
  input  logic [VEL_W-1:0]   vel_i,
  output logic [COORD_W-1:0] result_o
);

  localparam int unsigned SumW = COORD_W + VEL_W + 2;
  localparam logic signed [SumW-1:0] MaxS = SumW'(MAX);

  logic signed [SumW-1:0] sum;

  // Two guard bits above the widest operand keep the sign of any sum exact.
  assign sum = $signed({{(VEL_W + 2){1'b0}}, coord_i}) + SumW'($signed(vel_i));

  always_comb begin
    result_o = COORD_W'(sum);
    if (sum < 0) begin
      result_o = (MODE == EDGE_WRAP) ? COORD_W'(sum + MaxS) : '0;
    end else if (sum >= MaxS) begin
      result_o = (MODE == EDGE_WRAP) ? COORD_W'(sum - MaxS) : COORD_W'(MaxS - 1);
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame sprite engine: steps every active slot once, then streams active slots out over a
// valid/ready handshake in slot order.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned CANVAS_WIDTH  = 100,
  parameter int unsigned CANVAS_HEIGHT = 100,
  parameter int unsigned NUM_FRAMES    = 100,
  parameter int unsigned MAX_SPRITES   = 4,
  parameter int unsigned VEL_WIDTH     = 4,
  parameter int unsigned EDGE_MODE     = EDGE_CLAMP
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic                             new_frame,
  input  logic                             wr_en,
  input  logic [$clog2(MAX_SPRITES)-1:0]   wr_idx,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]  wr_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0] wr_y,
  input  logic [VEL_WIDTH-1:0]             wr_dx,
  input  logic [VEL_WIDTH-1:0]             wr_dy,
  input  logic                             wr_active,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] y,
  output logic [$clog2(NUM_FRAMES)-1:0]    frame,
  output logic [$clog2(MAX_SPRITES)-1:0]   sprite_idx,
  output logic                             sprite_valid,
  input  logic                             sprite_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             frame_overrun
);

  localparam int unsigned XW = $clog2(CANVAS_WIDTH);
  localparam int unsigned YW = $clog2(CANVAS_HEIGHT);
  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned IW = $clog2(MAX_SPRITES);
  localparam int unsigned MinDim = (CANVAS_WIDTH < CANVAS_HEIGHT) ? CANVAS_WIDTH : CANVAS_HEIGHT;
  localparam logic [IW-1:0] LastSlot = IW'(MAX_SPRITES - 1);
  localparam logic [SLOT_FRAME_W-1:0] LastFrame = SLOT_FRAME_W'(NUM_FRAMES - 1);

  if ((2 ** (VEL_WIDTH - 1)) > MinDim) begin : g_vel_check
    $error("sprite_scheduler: 2**(VEL_WIDTH-1) must not exceed the smaller canvas dimension");
  end

  if ((XW > SLOT_COORD_W) || (YW > SLOT_COORD_W) || (FW > SLOT_FRAME_W) ||
      (VEL_WIDTH > SLOT_VEL_W) || (VEL_WIDTH < 2) || (MAX_SPRITES < 2) ||
      (NUM_FRAMES < 2) || (EDGE_MODE > EDGE_WRAP)) begin : g_width_check
    $error("sprite_scheduler: parameters out of supported range");
  end

  sched_state_t  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  sprite_slot_t  table_q [MAX_SPRITES];
  sprite_slot_t  table_d [MAX_SPRITES];
  sprite_slot_t  cur;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          load;

  logic [SLOT_COORD_W-1:0] step_x, step_y;

  assign cur = table_q[ptr_q];

  edge_step #(
    .MAX    (CANVAS_WIDTH),
    .MODE   (EDGE_MODE),
    .COORD_W(SLOT_COORD_W),
    .VEL_W  (SLOT_VEL_W)
  ) u_edge_x (
    .coord_i (cur.x),
    .vel_i   (cur.dx),
    .result_o(step_x)
  );

  edge_step #(
    .MAX    (CANVAS_HEIGHT),
    .MODE   (EDGE_MODE),
    .COORD_W(SLOT_COORD_W),
    .VEL_W  (SLOT_VEL_W)
  ) u_edge_y (
    .coord_i (cur.y),
    .vel_i   (cur.dy),
    .result_o(step_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    table_d = table_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The write lands in table_d, so an UPDATE starting this cycle sees it next cycle.
        if (wr_en) begin
          table_d[wr_idx] = '{
            active: wr_active,
            x:      SLOT_COORD_W'(wr_x),
            y:      SLOT_COORD_W'(wr_y),
            dx:     SLOT_VEL_W'($signed(wr_dx)),
            dy:     SLOT_VEL_W'($signed(wr_dy)),
            frame:  '0
          };
        end
        if (new_frame) begin
          state_d = StUpdate;
          ptr_d   = '0;
        end
      end

      StUpdate: begin
        if (cur.active) begin
          table_d[ptr_q].x     = step_x;
          table_d[ptr_q].y     = step_y;
          table_d[ptr_q].frame = (cur.frame == LastFrame) ? '0 :
                                 cur.frame + SLOT_FRAME_W'(1);
        end
        ptr_d = ptr_q + IW'(1);
        if (ptr_q == LastSlot) begin
          state_d = StEmit;
          ptr_d   = '0;
          load    = 1'b1;
        end
      end

      StEmit: begin
        // valid_q low means the current slot is inactive and is skipped this cycle.
        if (!valid_q || sprite_ready) begin
          ptr_d = ptr_q + IW'(1);
          if (ptr_q == LastSlot) begin
            state_d = StIdle;
            ptr_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase

    if (load) begin
      valid_d = table_d[ptr_d].active;
      x_d     = table_d[ptr_d].x[XW-1:0];
      y_d     = table_d[ptr_d].y[YW-1:0];
      frame_d = table_d[ptr_d].frame[FW-1:0];
      idx_d   = ptr_d;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      table_q <= '{default: '0};
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      table_q <= table_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign frame         = frame_q;
  assign sprite_idx    = idx_q;
  assign sprite_valid  = valid_q;
  assign frame_done    = done_q;
  assign busy          = (state_q != StIdle);
  assign frame_overrun = new_frame && busy && !rst_in;

endmodule
